jk_channel_bank: RTL

JK_CHANNEL_BANK -- requirements
Module: jk_channel_bank

---
 rtl/jk_channel_bank.sv | 113 +++++++++++
 1 files changed

// File: rtl/jk_channel_bank.sv
// rtl/jk_channel_bank.sv - bank of independent OFF/LOCK/ON channels with min on-time and auto-off
module jk_channel_bank #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic [N_CH-1:0]            j,
    input  logic [N_CH-1:0]            k,
    input  logic                       retrig,
    input  logic [CNT_W-1:0]           min_on,
    input  logic [CNT_W-1:0]           timeout,
    output logic [N_CH-1:0]            out,
    output logic [$clog2(N_CH+1)-1:0]  on_count,
    output logic [N_CH-1:0]            timeout_evt
);

    localparam int CW = $clog2(N_CH+1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_LOCK = 2'd1,
        S_ON   = 2'd2
    } state_t;

    // Comparisons run one bit wider so counter+1 never wraps.
    logic [CNT_W:0] w_min_eff;
    logic [CNT_W:0] w_timeout;
    logic           w_to_en;

    assign w_min_eff = (min_on == '0) ? (CNT_W+1)'(1) : {1'b0, min_on};
    assign w_timeout = {1'b0, timeout};
    assign w_to_en   = |timeout;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            state_t           r_state;
            logic [CNT_W-1:0] r_dwell;
            logic [CNT_W-1:0] r_timer;
            logic             r_evt;
            logic [CNT_W:0]   w_dwell_nx;
            logic [CNT_W:0]   w_timer_nx;

            assign w_dwell_nx = {1'b0, r_dwell} + (CNT_W+1)'(1);
            assign w_timer_nx = {1'b0, r_timer} + (CNT_W+1)'(1);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_state <= S_OFF;
                    r_dwell <= '0;
                    r_timer <= '0;
                    r_evt   <= 1'b0;
                end else if (clr) begin
                    r_state <= S_OFF;
                    r_dwell <= '0;
                    r_timer <= '0;
                    r_evt   <= 1'b0;
                end else begin
                    r_evt <= 1'b0;
                    case (r_state)
                        S_OFF: begin
                            if (j[g]) begin
                                r_state <= S_LOCK;
                                r_dwell <= '0;
                            end
                        end
                        S_LOCK: begin
                            if (w_dwell_nx < w_min_eff) begin
                                if (!w_dwell_nx[CNT_W])
                                    r_dwell <= w_dwell_nx[CNT_W-1:0];
                            end else if (k[g]) begin
                                r_state <= S_OFF;
                            end else begin
                                r_state <= S_ON;
                                r_timer <= '0;
                            end
                        end
                        S_ON: begin
                            // k wins over retrigger, retrigger skips the timeout check.
                            if (k[g]) begin
                                r_state <= S_OFF;
                            end else if (retrig && j[g]) begin
                                r_timer <= '0;
                            end else if (w_to_en && (w_timer_nx >= w_timeout)) begin
                                r_state <= S_OFF;
                                r_evt   <= 1'b1;
                            end else if (!w_timer_nx[CNT_W]) begin
                                r_timer <= w_timer_nx[CNT_W-1:0];
                            end
                        end
                        default: r_state <= S_OFF;
                    endcase
                end
            end

            assign out[g]         = (r_state != S_OFF);
            assign timeout_evt[g] = r_evt;
        end
    endgenerate

    logic [CW-1:0] w_count;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < N_CH; i++)
            w_count = w_count + CW'(out[i]);
    end

    assign on_count = w_count;

endmodule
